// File: rtl/color_seq_pkg.sv
// Shared types and helpers for the color-mode sequencer: FSM mode encoding,
// FSM command codes, sequencer state encoding and path-planning helpers.
package color_seq_pkg;

    // Mode of the nested color-state FSM as tracked by the shadow register.
    typedef enum logic [1:0] {
        BLUE    = 2'd0,
        RED     = 2'd1,
        HSV     = 2'd2,
        INVALID = 2'd3
    } mode_t;

    // Commands understood by the FSM `in` port.
    localparam logic [1:0] CMD_TO_RED_FROM_HSV = 2'd0;
    localparam logic [1:0] CMD_TOGGLE          = 2'd1;
    localparam logic [1:0] CMD_TO_HSV          = 2'd2;
    localparam logic [1:0] CMD_HOLD            = 2'd3;

    // Sequencer state enumeration.
    typedef logic [2:0] seq_state_t;
    localparam seq_state_t ST_IDLE   = 3'd0;
    localparam seq_state_t ST_CHECK  = 3'd1;
    localparam seq_state_t ST_STEP   = 3'd2;
    localparam seq_state_t ST_SETTLE = 3'd3;
    localparam seq_state_t ST_DONE   = 3'd4;

    // Red is the hub of the mode graph: every hop lands on Red unless we are
    // already there, in which case the hop goes straight to the target.
    function automatic mode_t next_hop(input mode_t cur, input mode_t tgt);
        return (cur == RED) ? tgt : RED;
    endfunction

    // Command that moves the FSM one hop from cur toward tgt.
    function automatic logic [1:0] hop_cmd(input mode_t cur, input mode_t tgt);
        logic [1:0] cmd;
        case (cur)
            BLUE:    cmd = CMD_TOGGLE;
            HSV:     cmd = CMD_TO_RED_FROM_HSV;
            default: cmd = (tgt == HSV) ? CMD_TO_HSV : CMD_TOGGLE;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/color_seq_rr_arb.sv
// Round-robin arbiter: rotating priority pointer plus one-hot winner.
// The search starts at the pointer; the pointer moves past the winner only
// when the winner is actually taken (advance).
module color_seq_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               any_req
);

    logic [IDX_W-1:0] ptr_reg;
    logic [IDX_W-1:0] cand_idx;

    // Scan from farthest to nearest so the request closest to the pointer
    // overwrites the others and ends up as the winner.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        any_req    = 1'b0;
        cand_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_idx = IDX_W'((int'(ptr_reg) + k) % NUM_REQ);
            if (req[cand_idx]) begin
                winner           = '0;
                winner[cand_idx] = 1'b1;
                winner_idx       = cand_idx;
                any_req          = 1'b1;
            end
        end
    end

    // Priority pointer: one past the last grant, wrapping at NUM_REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg <= '0;
        end else if (advance) begin
            ptr_reg <= (winner_idx == IDX_W'(NUM_REQ - 1)) ? '0 : winner_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/color_mode_sequencer.sv
// Color-mode sequencer: shares the nested Blue/Red/HSV color FSM among
// NUM_REQ requesters, plans the hop path through Red, drives the FSM command
// one hop at a time with HOLD_CYCLES of hold command after each hop, and
// keeps a shadow copy of the FSM mode.
// Optional build macro COLOR_SEQ_STATS_EN adds a saturating hop counter port.
module color_mode_sequencer
    import color_seq_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [2*NUM_REQ-1:0] req_mode,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic                 err,
    output logic [1:0]           fsm_cmd,
    output logic [1:0]           cur_mode,
    output logic                 busy
`ifdef COLOR_SEQ_STATS_EN
    ,
    output logic [15:0]          hop_count
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

    seq_state_t         state_reg, state_next;
    logic [NUM_REQ-1:0] gnt_reg, gnt_next;
    mode_t              target_reg, target_next;
    mode_t              cur_mode_reg, cur_mode_next;
    logic [CNT_W-1:0]   hold_cnt_reg, hold_cnt_next;

    logic [NUM_REQ-1:0] winner;
    logic [IDX_W-1:0]   winner_idx;
    logic               any_req;
    logic               arb_take;
    logic [1:0]         mode_slice [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_mode_slice
            assign mode_slice[gi] = req_mode[2*gi +: 2];
        end
    endgenerate

    assign arb_take = (state_reg == ST_IDLE) && any_req;

    color_seq_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .advance    (arb_take),
        .winner     (winner),
        .winner_idx (winner_idx),
        .any_req    (any_req)
    );

    // Next-state logic: grant/target capture, path stepping, settle timing.
    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        target_next   = target_reg;
        cur_mode_next = cur_mode_reg;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_next    = winner;
                    target_next = mode_t'(mode_slice[winner_idx]);
                    state_next  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (target_reg == INVALID || target_reg == cur_mode_reg) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_STEP;
                end
            end
            ST_STEP: begin
                cur_mode_next = next_hop(cur_mode_reg, target_reg);
                hold_cnt_next = CNT_W'(HOLD_CYCLES);
                state_next    = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (hold_cnt_reg <= CNT_W'(1)) begin
                    // A pending second hop is issued straight from SETTLE so
                    // each extra hop costs exactly HOLD_CYCLES+1 cycles; the
                    // final re-check only happens once the target is reached.
                    state_next = (target_reg != cur_mode_reg) ? ST_STEP : ST_CHECK;
                end else begin
                    hold_cnt_next = hold_cnt_reg - CNT_W'(1);
                end
            end
            ST_DONE: begin
                gnt_next   = '0;
                state_next = ST_IDLE;
            end
            default: begin
                gnt_next   = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    // State registers; reset leaves the shadow mode at Red to match the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            gnt_reg      <= '0;
            target_reg   <= RED;
            cur_mode_reg <= RED;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            target_reg   <= target_next;
            cur_mode_reg <= cur_mode_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    assign gnt      = gnt_reg;
    assign done     = (state_reg == ST_DONE) ? gnt_reg : '0;
    assign err      = (state_reg == ST_DONE) && (target_reg == INVALID);
    assign fsm_cmd  = (state_reg == ST_STEP) ? hop_cmd(cur_mode_reg, target_reg) : CMD_HOLD;
    assign cur_mode = cur_mode_reg;
    assign busy     = (state_reg != ST_IDLE);

`ifdef COLOR_SEQ_STATS_EN
    logic [15:0] hop_count_reg;

    // Saturating count of issued hops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hop_count_reg <= '0;
        end else if (state_reg == ST_STEP && hop_count_reg != 16'hFFFF) begin
            hop_count_reg <= hop_count_reg + 16'd1;
        end
    end

    assign hop_count = hop_count_reg;
`endif

endmodule
